aes_key_sched_ctrl: RTL and testbench
=====================================

// Module: aes_key_sched_ctrl
// PURPOSE
//   Sequencer for AES-128 key expansion around the shared g-function datapath
//   (RotWord + SubWord + Rcon XOR). Loads a 128-bit cipher key, drives the
//   g-datapath once per round with w[3] and Rcon, and builds
//   w'[0]=w[0]^g, w'[1]=w[1]^w'[0], w'[2]=w[2]^w'[1], w'[3]=w[3]^w'[2].
//   Streams round keys 0..10 to the cipher core over a valid/ready interface.
// PARAMETERS
//   G_LATENCY  0  cycles from g_req_o rise to g_result_i valid (legal 0..3)
// PORTS
//   clk         in   1    system clock, all state on rising edge
//   rst_n       in   1    asynchronous active-low reset
//   start_i     in   1    begin expansion of key_i; honoured only in IDLE
//   key_i       in   128  cipher key, {w0,w1,w2,w3}, w0 = bits [127:96]
//   busy_o      out  1    high from start acceptance until done_o
//   g_req_o     out  1    high while g_word_o/g_rcon_o are presented
//   g_word_o    out  32   current w[3] into the g-datapath
//   g_rcon_o    out  8    current round constant into the g-datapath
//   g_result_i  in   32   g-function result
//   rk_valid_o  out  1    rk_o/rk_idx_o valid
//   rk_ready_i  in   1    consumer accepts round key
//   rk_o        out  128  round key {w0,w1,w2,w3}
//   rk_idx_o    out  4    round index 0..10
//   done_o      out  1    one-cycle pulse after round key 10 is accepted
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, rcon register = 8'h01, key regs = 0.
// - FSM: IDLE -> EMIT (start_i) -> GCALC (handshake, idx<10) -> EMIT ...;
//   EMIT with idx=10 + handshake -> IDLE, done_o=1 for that next cycle.
// - IDLE: start_i=1 latches key_i, idx=0, rcon=01; rk_valid_o rises next cycle.
// - EMIT: rk_valid_o=1; rk_o/rk_idx_o held stable until rk_valid_o&rk_ready_i.
// - GCALC: lasts G_LATENCY+1 cycles; g_req_o=1 throughout, g_word_o/g_rcon_o
//   stable; g_result_i sampled on last GCALC cycle; next key, idx+1 and
//   rcon=xtime(rcon) registered on that edge; g_req_o=0 outside GCALC.
// - xtime: rcon<<1, XOR 8'h1b if rcon[7] set: 01,02,04,08,10,20,40,80,1b,36.
// - Throughput with rk_ready_i=1: one key every G_LATENCY+2 cycles;
//   11 keys complete in 10*(G_LATENCY+2)+1 cycles after start_i.
// - start_i while busy_o=1: ignored, no effect on key or sequence.
// - start_i in the cycle done_o is high: accepted (state is IDLE).
// - rk_ready_i low during GCALC: no effect; backpressure only stalls EMIT.
// - rst_n low mid-expansion: immediate return to reset values; no done_o.
// - g_word_o/g_rcon_o hold last values in EMIT/IDLE (don't-care to datapath).
// CONFIGURATION
// - AES_KEY_STORE_EN defined: 11x128 register file written at each EMIT
//   entry; adds ports rd_idx_i (in,4), rd_key_o (out,128, combinational read,
//   0 for idx>10), store_valid_o (out,1: set at done_o, cleared on next
//   accepted start_i or reset). Serves decryption in reverse order.
// - Not defined: no storage, extra ports absent; keys only streamed.
// TESTING (bench drives g_result_i from a FIPS-197 g-function model)
// - Key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready_i=1, G_LATENCY=0 ->
//   idx1 a0fafe17_88542cb1_23a33939_2a6c7605, idx10 d014f9a8_c9ee2589_
//   e13f0cc8_b6630ca6; done_o 21 cycles after start_i.
// - Same key, g_rcon_o per GCALC -> 01,02,04,08,10,20,40,80,1b,36 in order.
// - rk_ready_i low 5 cycles at idx 3 -> rk_o/rk_idx_o frozen, no g_req_o,
//   sequence resumes with identical key values.
// - start_i pulsed mid-run with different key_i -> ignored; output keys match
//   original key; busy_o stays 1 until done_o.
// - rst_n low at idx 6 -> all outputs 0 next sample; fresh start_i gives
//   correct idx0..10; G_LATENCY=3 run -> key spacing 5 cycles, same values.
// - AES_KEY_STORE_EN: after done_o, rd_idx_i=10 -> d014f9a8_..._b6630ca6,
//   rd_idx_i=0 -> input key, rd_idx_i=15 -> 0; store_valid_o=1.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
//   Sequencer for AES-128 key expansion around a shared, external g-function
//   datapath (RotWord + SubWord + Rcon XOR). Loads a cipher key, requests one
//   g evaluation per round and streams round keys 0..10 over valid/ready.
//
//   Optional feature macro: AES_KEY_STORE_EN
//     Adds an 11 x 128 round-key store (written on every EMIT entry) with a
//     combinational read port for reverse-order (decryption) consumers.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i, key_i      begin expansion of key_i {w0,w1,w2,w3} (IDLE only)
//   busy_o              high from start acceptance until done_o
//   g_req_o             g-datapath request, high throughout GCALC
//   g_word_o, g_rcon_o  w[3] and round constant presented to the g-datapath
//   g_result_i          g-function result, sampled on the last GCALC cycle
//   rk_valid_o/ready_i  round-key handshake
//   rk_o, rk_idx_o      round key and its index 0..10
//   done_o              one-cycle pulse after round key 10 is accepted
//   rd_idx_i, rd_key_o, store_valid_o   (AES_KEY_STORE_EN only) key store
module aes_key_sched_ctrl #(
  parameter int unsigned G_LATENCY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         g_req_o,
  output logic [31:0]  g_word_o,
  output logic [7:0]   g_rcon_o,
  input  logic [31:0]  g_result_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
`ifdef AES_KEY_STORE_EN
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_key_o,
  output logic         store_valid_o,
`endif
  output logic         done_o
);

  localparam int unsigned KEY_W    = 128;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned RCON_W   = 8;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned CNT_W    = 2;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(10);
  localparam logic [RCON_W-1:0] RCON_0   = RCON_W'(8'h01);

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_GCALC} state_e;

  state_e              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RCON_W-1:0]   rcon_q, rcon_d;
  logic [CNT_W-1:0]    gcnt_q, gcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                g_req_q, g_req_d;
  logic [WORD_W-1:0]   g_word_q, g_word_d;
  logic [RCON_W-1:0]   g_rcon_q, g_rcon_d;
  logic                rk_valid_q, rk_valid_d;

  // Next round key: each word chains off the freshly computed previous word.
  logic [WORD_W-1:0]   nw0_c, nw1_c, nw2_c, nw3_c;
  logic [RCON_W-1:0]   rcon_x_c;

  assign nw0_c    = key_q[127:96] ^ g_result_i;
  assign nw1_c    = key_q[95:64]  ^ nw0_c;
  assign nw2_c    = key_q[63:32]  ^ nw1_c;
  assign nw3_c    = key_q[31:0]   ^ nw2_c;
  assign rcon_x_c = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? RCON_W'(8'h1b) : RCON_W'(8'h00));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      idx_q      <= '0;
      rcon_q     <= RCON_0;
      gcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      g_req_q    <= 1'b0;
      g_word_q   <= '0;
      g_rcon_q   <= '0;
      rk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      idx_q      <= idx_d;
      rcon_q     <= rcon_d;
      gcnt_q     <= gcnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      g_req_q    <= g_req_d;
      g_word_q   <= g_word_d;
      g_rcon_q   <= g_rcon_d;
      rk_valid_q <= rk_valid_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    idx_d      = idx_q;
    rcon_d     = rcon_q;
    gcnt_d     = gcnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    g_req_d    = g_req_q;
    g_word_d   = g_word_q;
    g_rcon_d   = g_rcon_q;
    rk_valid_d = rk_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          key_d      = key_i;
          idx_d      = '0;
          rcon_d     = RCON_0;
          busy_d     = 1'b1;
          rk_valid_d = 1'b1;
          state_d    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready_i) begin
          rk_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            g_req_d  = 1'b1;
            g_word_d = key_q[31:0];
            g_rcon_d = rcon_q;
            gcnt_d   = '0;
            state_d  = ST_GCALC;
          end
        end
      end
      ST_GCALC: begin
        // Result is taken on the final cycle of the G_LATENCY+1 cycle window.
        if (gcnt_q == CNT_W'(G_LATENCY)) begin
          key_d      = {nw0_c, nw1_c, nw2_c, nw3_c};
          idx_d      = idx_q + IDX_W'(1);
          rcon_d     = rcon_x_c;
          g_req_d    = 1'b0;
          rk_valid_d = 1'b1;
          state_d    = ST_EMIT;
        end else begin
          gcnt_d = gcnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign g_req_o    = g_req_q;
  assign g_word_o   = g_word_q;
  assign g_rcon_o   = g_rcon_q;
  assign rk_valid_o = rk_valid_q;
  assign rk_o       = key_q;
  assign rk_idx_o   = idx_q;

`ifdef AES_KEY_STORE_EN
  logic [KEY_W-1:0] store_q [0:10];
  logic             store_valid_q, store_valid_d;
  logic             store_we_c;

  // Capture each round key as it enters EMIT.
  assign store_we_c = (state_d == ST_EMIT) && (state_q != ST_EMIT);

  always_comb begin
    store_valid_d = store_valid_q;
    if (done_d) begin
      store_valid_d = 1'b1;
    end else if ((state_q == ST_IDLE) && start_i) begin
      store_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_valid_q <= 1'b0;
      for (int i = 0; i < 11; i++) store_q[i] <= '0;
    end else begin
      store_valid_q <= store_valid_d;
      if (store_we_c && (idx_d <= LAST_IDX)) store_q[idx_d] <= key_d;
    end
  end

  assign store_valid_o = store_valid_q;
  assign rd_key_o      = (rd_idx_i <= LAST_IDX) ? store_q[rd_idx_i] : '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: two instances (G_LATENCY 0 and 3) fed by a
// FIPS-197 g-function model; expected round keys are queued at start and
// popped on every rk handshake.
module tb_aes_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance with G_LATENCY = 0
  logic         start_i, busy, g_req, rk_valid, rk_ready, done;
  logic [127:0] key_i, rk;
  logic [31:0]  g_word, g_result;
  logic [7:0]   g_rcon;
  logic [3:0]   rk_idx;
  // Instance with G_LATENCY = 3
  logic         start3, busy3, g_req3, rk_valid3, rk_ready3, done3;
  logic [127:0] key3, rk3;
  logic [31:0]  g_word3, g_result3;
  logic [7:0]   g_rcon3;
  logic [3:0]   rk_idx3;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx, rd_idx3;
  logic [127:0] rd_key, rd_key3;
  logic         store_valid, store_valid3;
`endif

  aes_key_sched_ctrl #(.G_LATENCY(0)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i),
    .busy_o(busy), .g_req_o(g_req), .g_word_o(g_word), .g_rcon_o(g_rcon),
    .g_result_i(g_result), .rk_valid_o(rk_valid), .rk_ready_i(rk_ready),
    .rk_o(rk), .rk_idx_o(rk_idx),
`ifdef AES_KEY_STORE_EN
    .rd_idx_i(rd_idx), .rd_key_o(rd_key), .store_valid_o(store_valid),
`endif
    .done_o(done)
  );

  aes_key_sched_ctrl #(.G_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start3), .key_i(key3),
    .busy_o(busy3), .g_req_o(g_req3), .g_word_o(g_word3), .g_rcon_o(g_rcon3),
    .g_result_i(g_result3), .rk_valid_o(rk_valid3), .rk_ready_i(rk_ready3),
    .rk_o(rk3), .rk_idx_o(rk_idx3),
`ifdef AES_KEY_STORE_EN
    .rd_idx_i(rd_idx3), .rd_key_o(rd_key3), .store_valid_o(store_valid3),
`endif
    .done_o(done3)
  );

  // ---------------- FIPS-197 reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, sq;
    r = 8'h01; sq = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, sq);
      sq = gmul(sq, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] gfun(input logic [31:0] w, input logic [7:0] rc);
    logic [31:0] rot;
    rot = {w[23:0], w[31:24]};
    return {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ gfun(k[31:0], rc);
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb g_result  = gfun(g_word, g_rcon);
  always_comb g_result3 = gfun(g_word3, g_rcon3);

  logic [7:0] rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // ---------------- scoreboard ----------------
  logic [131:0] q[$];
  logic [131:0] q3[$];
  logic [7:0]   rq[$];
  logic [127:0] ek   [0:10];
  logic [127:0] got  [0:10];
  logic [127:0] last_key = '0;
  logic         g_req_prev = 1'b0;
  bit           rec_en = 1'b0;
  int           last3 = -1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor for the latency-0 instance.
  always @(negedge clk) begin
    logic [131:0] e;
    if (rst_n) begin
      if (g_req && !g_req_prev) begin
        chk("g_word", {96'b0, g_word}, {96'b0, last_key[31:0]});
        if (rq.size() == 0) chk("g_rcon_unexpected", 128'(rq.size()), 128'd1);
        else                chk("g_rcon", {120'b0, g_rcon}, {120'b0, rq.pop_front()});
      end
      if (rk_valid && rk_ready) begin
        if (q.size() == 0) chk("rk_unexpected", 128'(q.size()), 128'd1);
        else begin
          e = q.pop_front();
          chk("rk_idx", {124'b0, rk_idx}, {124'b0, e[131:128]});
          chk("rk", rk, e[127:0]);
          last_key = rk;
          if (rec_en && rk_idx <= 4'd10) got[rk_idx] = rk;
        end
      end
    end
    g_req_prev = g_req;
  end

  // Monitor for the latency-3 instance: values plus key spacing.
  always @(negedge clk) begin
    logic [131:0] e;
    if (rst_n && rk_valid3 && rk_ready3) begin
      if (q3.size() == 0) chk("rk3_unexpected", 128'(q3.size()), 128'd1);
      else begin
        e = q3.pop_front();
        chk("rk3_idx", {124'b0, rk_idx3}, {124'b0, e[131:128]});
        chk("rk3", rk3, e[127:0]);
        if (last3 >= 0) chk("rk3_spacing", 128'(cyc - last3), 128'd5);
        last3 = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [127:0] k);
    logic [127:0] cur;
    cur = k;
    for (int i = 0; i < 11; i++) begin
      q.push_back({4'(i), cur});
      ek[i] = cur;
      if (i < 10) begin
        rq.push_back(rcon_tab[i]);
        cur = next_key(cur, rcon_tab[i]);
      end
    end
    key_i   = k;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Cycles from the start-sampling edge until done_o is seen; -1 on timeout.
  task automatic wait_done(input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (done === 1'b1) begin
        n = k;
        break;
      end
    end
    if (n < 0) chk("done_timeout", 128'(n), 128'(bound));
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_rk_valid"}, {127'b0, rk_valid}, 128'd0);
    chk({pfx, "_busy"},     {127'b0, busy},     128'd0);
    chk({pfx, "_done"},     {127'b0, done},     128'd0);
    chk({pfx, "_g_req"},    {127'b0, g_req},    128'd0);
    chk({pfx, "_rk"},       rk,                 128'd0);
    chk({pfx, "_rk_idx"},   {124'b0, rk_idx},   128'd0);
    chk({pfx, "_g_word"},   {96'b0, g_word},    128'd0);
    chk({pfx, "_g_rcon"},   {120'b0, g_rcon},   128'd0);
  endtask

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3 = 128'h00112233445566778899aabbccddeeff;

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic [127:0] cur;
    rst_n = 1'b0; start_i = 1'b0; key_i = '0; rk_ready = 1'b1;
    start3 = 1'b0; key3 = '0; rk_ready3 = 1'b1;
`ifdef AES_KEY_STORE_EN
    rd_idx = '0; rd_idx3 = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Run 1: reference key, full-rate consumer.
    rec_en = 1'b1;
    start_run(K1);
    wait_done(40, n);
    rec_en = 1'b0;
    chk("done_latency", 128'(n), 128'd21);
    chk("busy_at_done", {127'b0, busy}, 128'd0);
`ifdef AES_KEY_STORE_EN
    chk("store_valid", {127'b0, store_valid}, 128'd1);
    rd_idx = 4'd10; #1;
    chk("store_rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_idx = 4'd0;  #1;
    chk("store_rd0", rd_key, K1);
    rd_idx = 4'd15; #1;
    chk("store_rd15", rd_key, 128'd0);
`endif
    tick();
    chk("done_pulse_width", {127'b0, done}, 128'd0);
    chk("rk1_fips", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("rk10_fips", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("run1_drained", 128'(q.size() + rq.size()), 128'd0);

    // Run 2: backpressure for 5 cycles on round key 3.
    start_run(K1);
    for (int k = 0; k < 40; k++) begin
      if (g_req && rk_idx == 4'd2) break;
      tick();
    end
    rk_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {127'b0, rk_valid}, 128'd1);
      chk("stall_idx", {124'b0, rk_idx}, 128'd3);
      chk("stall_rk", rk, ek[3]);
      chk("stall_no_greq", {127'b0, g_req}, 128'd0);
      tick();
    end
    rk_ready = 1'b1;
    wait_done(60, n);
    chk("run2_drained", 128'(q.size() + rq.size()), 128'd0);
    tick();

    // Run 3: start pulse with another key mid-run must be ignored.
    start_run(K1);
    for (int k = 0; k < 40; k++) begin
      if (rk_valid && rk_idx == 4'd4) break;
      tick();
    end
    key_i = K2; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = -1;
    for (int k = 0; k < 60; k++) begin
      if (done === 1'b1) begin
        n = k;
        break;
      end
      chk("busy_hold", {127'b0, busy}, 128'd1);
      tick();
    end
    if (n < 0) chk("run3_done_timeout", 128'(n), 128'd0);
    chk("run3_drained", 128'(q.size() + rq.size()), 128'd0);
    tick();

    // Run 4: asynchronous reset at round key 6, then fresh runs.
    start_run(K2);
    for (int k = 0; k < 40; k++) begin
      if (rk_valid && rk_idx == 4'd6) break;
      tick();
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midrst");
    q.delete(); rq.delete(); last_key = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("no_done_after_rst", {127'b0, done}, 128'd0);
    start_run(K2);
    wait_done(40, n);
    chk("run4_latency", 128'(n), 128'd21);
    // Start issued in the done_o cycle is accepted.
    start_run(K3);
    chk("restart_busy", {127'b0, busy}, 128'd1);
    chk("restart_valid", {127'b0, rk_valid}, 128'd1);
    chk("restart_rk0", rk, K3);
    wait_done(40, n);
    chk("run5_drained", 128'(q.size() + rq.size()), 128'd0);
    tick();

    // Run 6: G_LATENCY=3 instance, same key values, 5-cycle spacing.
    cur = K1;
    for (int i = 0; i < 11; i++) begin
      q3.push_back({4'(i), cur});
      if (i < 10) cur = next_key(cur, rcon_tab[i]);
    end
    key3 = K1; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = -1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (done3 === 1'b1) begin
        n = k;
        break;
      end
    end
    chk("lat3_done_latency", 128'(n), 128'd51);
    chk("lat3_drained", 128'(q3.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
